// File: rtl/gpr_wb_select_reg.sv
// rtl/gpr_wb_select_reg.sv - registered GPR write-back stage: source select, load extension, write strobe.
// Optional forwarding port enabled by defining WB_BYPASS_EN.
module gpr_wb_select_reg #(
  parameter int WIDTH    = 32,
  parameter int NUM_SRC  = 6,
  parameter int SEL_W    = 3,
  parameter int ADDR_W   = 5,
  parameter int LOAD_SEL = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [SEL_W-1:0]         sel,
  input  logic [2:0]               ext_mode,
  input  logic [1:0]               byte_off,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic                     wb_req,
  output logic                     wb_ready,
  input  logic                     gpr_stall,
  output logic                     gpr_we,
  output logic [ADDR_W-1:0]        gpr_waddr,
  output logic [WIDTH-1:0]         gpr_wdata,
  output logic                     fwd_valid,
  output logic [ADDR_W-1:0]        fwd_addr,
  output logic [WIDTH-1:0]         fwd_data
);

  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [SEL_W-1:0] LOAD_SEL_V = SEL_W'(LOAD_SEL);

  localparam logic [2:0] EXT_LB  = 3'b001;
  localparam logic [2:0] EXT_LBU = 3'b010;
  localparam logic [2:0] EXT_LH  = 3'b011;
  localparam logic [2:0] EXT_LHU = 3'b100;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cap_addr, cap_addr_nxt;
  logic [WIDTH-1:0]  cap_data, cap_data_nxt;

  logic [WIDTH-1:0]  src_word;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [WIDTH-1:0]  ext_word;

  // Out-of-range selects fall back to the last source.
  always_comb begin
    src_word = src_data[(NUM_SRC-1)*WIDTH +: WIDTH];
    for (int k = 0; k < NUM_SRC; k++) begin
      if (32'(sel) == k) src_word = src_data[k*WIDTH +: WIDTH];
    end
  end

  assign lane_byte = src_word[{byte_off, 3'b000} +: 8];
  assign lane_half = src_word[{byte_off[1], 4'b0000} +: 16];

  always_comb begin
    ext_word = src_word;
    if (sel == LOAD_SEL_V) begin
      case (ext_mode)
        EXT_LB:  ext_word = {{(WIDTH-8){lane_byte[7]}}, lane_byte};
        EXT_LBU: ext_word = {{(WIDTH-8){1'b0}}, lane_byte};
        EXT_LH:  ext_word = {{(WIDTH-16){lane_half[15]}}, lane_half};
        EXT_LHU: ext_word = {{(WIDTH-16){1'b0}}, lane_half};
        default: ext_word = src_word;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cap_addr <= '0;
      cap_data <= '0;
    end else begin
      state    <= state_nxt;
      cap_addr <= cap_addr_nxt;
      cap_data <= cap_data_nxt;
    end
  end

  // Requests arriving while a write is pending are dropped, not queued.
  always_comb begin
    state_nxt    = state;
    cap_addr_nxt = cap_addr;
    cap_data_nxt = cap_data;
    wb_ready     = 1'b0;
    gpr_we       = 1'b0;
    case (state)
      IDLE: begin
        wb_ready = 1'b1;
        if (wb_req) begin
          cap_addr_nxt = wb_addr;
          cap_data_nxt = ext_word;
          state_nxt    = WRITE;
        end
      end
      WRITE: begin
        gpr_we = (cap_addr != '0);
        if (!gpr_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gpr_waddr = cap_addr;
  assign gpr_wdata = cap_data;

`ifdef WB_BYPASS_EN
  assign fwd_valid = (state == WRITE) && (cap_addr != '0);
  assign fwd_addr  = fwd_valid ? cap_addr : '0;
  assign fwd_data  = fwd_valid ? cap_data : '0;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_gpr_wb_select_reg.sv
// tb/tb_gpr_wb_select_reg.sv - directed self-checking bench for gpr_wb_select_reg.
// Forwarding expectations follow WB_BYPASS_EN.
module tb_gpr_wb_select_reg;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [191:0] src_data = '0;
  logic [2:0]   sel = '0;
  logic [2:0]   ext_mode = '0;
  logic [1:0]   byte_off = '0;
  logic [4:0]   wb_addr = '0;
  logic         wb_req = 1'b0;
  logic         wb_ready;
  logic         gpr_stall = 1'b0;
  logic         gpr_we;
  logic [4:0]   gpr_waddr;
  logic [31:0]  gpr_wdata;
  logic         fwd_valid;
  logic [4:0]   fwd_addr;
  logic [31:0]  fwd_data;

  int tests = 0;
  int fails = 0;

  gpr_wb_select_reg #(.WIDTH(32), .NUM_SRC(6), .SEL_W(3), .ADDR_W(5), .LOAD_SEL(1)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .sel(sel), .ext_mode(ext_mode),
    .byte_off(byte_off), .wb_addr(wb_addr), .wb_req(wb_req), .wb_ready(wb_ready),
    .gpr_stall(gpr_stall), .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic set_src(input int k, input logic [31:0] v);
    src_data[k*32 +: 32] = v;
  endtask

  // Present one request for exactly one capture edge; returns 1 time unit after that edge.
  task automatic issue(input logic [2:0] s, input logic [2:0] m, input logic [1:0] off,
                       input logic [4:0] a);
    @(posedge clk); #1;
    sel = s; ext_mode = m; byte_off = off; wb_addr = a; wb_req = 1'b1;
    @(posedge clk); #1;
    wb_req = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    tests++; if (gpr_we !== 1'b0) begin $display("FAIL reset_we got %b exp 0", gpr_we); fails++; end
    tests++; if (gpr_waddr !== 5'd0 || gpr_wdata !== 32'd0) begin
      $display("FAIL reset_regs got %h/%h exp 0/0", gpr_waddr, gpr_wdata); fails++; end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (wb_ready !== 1'b1) begin $display("FAIL reset_ready got %b exp 1", wb_ready); fails++; end
    // Async reset while a stalled write is pending.
    set_src(3, 32'hA5A5_5A5A);
    gpr_stall = 1'b1;
    issue(3'd3, 3'd0, 2'd0, 5'd3);
    @(negedge clk);
    tests++; if (gpr_we !== 1'b1 || gpr_wdata !== 32'hA5A5_5A5A) begin
      $display("FAIL rst_pre_we got %b/%h exp 1/a5a55a5a", gpr_we, gpr_wdata); fails++; end
    #2 rst = 1'b1;
    #1;
    tests++; if (gpr_we !== 1'b0 || gpr_waddr !== 5'd0 || gpr_wdata !== 32'd0 || fwd_valid !== 1'b0) begin
      $display("FAIL rst_async got we=%b a=%h d=%h fv=%b exp 0", gpr_we, gpr_waddr, gpr_wdata, fwd_valid);
      fails++; end
    @(posedge clk); #1 rst = 1'b0; gpr_stall = 1'b0;
    @(negedge clk);
    tests++; if (wb_ready !== 1'b1 || gpr_we !== 1'b0) begin
      $display("FAIL rst_release got rdy=%b we=%b exp 1/0", wb_ready, gpr_we); fails++; end
    @(negedge clk);
    tests++; if (gpr_we !== 1'b0) begin $display("FAIL rst_discard got %b exp 0", gpr_we); fails++; end
  endtask

  task automatic test_select;
    logic [31:0] exp;
    for (int k = 0; k < 6; k++) set_src(k, 32'h1111_1111 * k);
    for (int s = 0; s < 8; s++) begin
      exp = 32'h1111_1111 * ((s > 5) ? 5 : s);
      issue(s[2:0], 3'd0, 2'd0, 5'd5);
      @(negedge clk);
      tests++; if (gpr_we !== 1'b1 || gpr_waddr !== 5'd5 || gpr_wdata !== exp) begin
        $display("FAIL sel%0d got we=%b a=%0d d=%h exp 1/5/%h", s, gpr_we, gpr_waddr, gpr_wdata, exp);
        fails++; end
      @(negedge clk);
      tests++; if (gpr_we !== 1'b0 || wb_ready !== 1'b1 || gpr_wdata !== exp) begin
        $display("FAIL sel%0d_after got we=%b rdy=%b d=%h exp 0/1/%h", s, gpr_we, wb_ready, gpr_wdata, exp);
        fails++; end
    end
  endtask

  task automatic test_load_ext;
    logic [2:0]  modes [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd3, 3'd5, 3'd1};
    logic [1:0]  offs  [8] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1, 2'd3};
    logic [2:0]  sels  [8] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0};
    logic [31:0] exps  [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                               32'h0000_0001, 32'hFFFF_80FF, 32'h80FF_7F01, 32'h80FF_7F01};
    set_src(0, 32'h80FF_7F01);
    set_src(1, 32'h80FF_7F01);
    for (int i = 0; i < 8; i++) begin
      issue(sels[i], modes[i], offs[i], 5'd6);
      @(negedge clk);
      tests++; if (gpr_we !== 1'b1 || gpr_wdata !== exps[i]) begin
        $display("FAIL ext%0d got we=%b d=%h exp 1/%h", i, gpr_we, gpr_wdata, exps[i]); fails++; end
      @(negedge clk);
    end
  endtask

  task automatic test_zero_addr;
    issue(3'd2, 3'd0, 2'd0, 5'd0);
    @(negedge clk);
    tests++; if (gpr_we !== 1'b0 || wb_ready !== 1'b0 || fwd_valid !== 1'b0) begin
      $display("FAIL r0_write got we=%b rdy=%b fv=%b exp 0/0/0", gpr_we, wb_ready, fwd_valid); fails++; end
    @(negedge clk);
    tests++; if (gpr_we !== 1'b0 || wb_ready !== 1'b1) begin
      $display("FAIL r0_after got we=%b rdy=%b exp 0/1", gpr_we, wb_ready); fails++; end
  endtask

  task automatic test_stall;
    int we_cycles = 0;
    int we_rises  = 0;
    logic prev_we = 1'b0;
    set_src(2, 32'h2222_2222);
    set_src(3, 32'h3333_3333);
    gpr_stall = 1'b1;
    issue(3'd2, 3'd0, 2'd0, 5'd7);
    sel = 3'd3; wb_addr = 5'd12; wb_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (gpr_we) begin
        we_cycles++;
        tests++; if (gpr_waddr !== 5'd7 || gpr_wdata !== 32'h2222_2222) begin
          $display("FAIL stall_hold c%0d got %0d/%h exp 7/22222222", c, gpr_waddr, gpr_wdata); fails++; end
      end
      if (gpr_we && !prev_we) we_rises++;
      prev_we = gpr_we;
      if (c == 4) begin gpr_stall = 1'b0; wb_req = 1'b0; end
    end
    tests++; if (we_cycles != 4) begin $display("FAIL stall_len got %0d exp 4", we_cycles); fails++; end
    tests++; if (we_rises != 1) begin $display("FAIL stall_writes got %0d exp 1", we_rises); fails++; end
  endtask

  task automatic test_back_to_back;
    set_src(4, 32'h4444_4444);
    set_src(5, 32'h5555_5555);
    issue(3'd4, 3'd0, 2'd0, 5'd10);
    sel = 3'd5; wb_addr = 5'd11; wb_req = 1'b1;
    @(negedge clk);
    tests++; if (gpr_we !== 1'b1 || gpr_waddr !== 5'd10 || gpr_wdata !== 32'h4444_4444) begin
      $display("FAIL b2b_first got %b/%0d/%h exp 1/10/44444444", gpr_we, gpr_waddr, gpr_wdata); fails++; end
    @(negedge clk);
    tests++; if (gpr_we !== 1'b0 || wb_ready !== 1'b1) begin
      $display("FAIL b2b_gap got we=%b rdy=%b exp 0/1", gpr_we, wb_ready); fails++; end
    @(posedge clk); #1 wb_req = 1'b0;
    @(negedge clk);
    tests++; if (gpr_we !== 1'b1 || gpr_waddr !== 5'd11 || gpr_wdata !== 32'h5555_5555) begin
      $display("FAIL b2b_second got %b/%0d/%h exp 1/11/55555555", gpr_we, gpr_waddr, gpr_wdata); fails++; end
    @(negedge clk);
    tests++; if (gpr_we !== 1'b0) begin $display("FAIL b2b_end got %b exp 0", gpr_we); fails++; end
  endtask

  task automatic test_bypass;
    set_src(2, 32'hDEAD_BEEF);
    issue(3'd2, 3'd0, 2'd0, 5'd9);
    @(negedge clk);
`ifdef WB_BYPASS_EN
    tests++; if (fwd_valid !== 1'b1 || fwd_addr !== 5'd9 || fwd_data !== 32'hDEAD_BEEF) begin
      $display("FAIL fwd_on got %b/%0d/%h exp 1/9/deadbeef", fwd_valid, fwd_addr, fwd_data); fails++; end
`else
    tests++; if (fwd_valid !== 1'b0 || fwd_addr !== 5'd0 || fwd_data !== 32'd0) begin
      $display("FAIL fwd_off got %b/%0d/%h exp 0/0/0", fwd_valid, fwd_addr, fwd_data); fails++; end
`endif
    tests++; if (gpr_we !== 1'b1 || gpr_wdata !== 32'hDEAD_BEEF) begin
      $display("FAIL fwd_write got %b/%h exp 1/deadbeef", gpr_we, gpr_wdata); fails++; end
    @(negedge clk);
    tests++; if (fwd_valid !== 1'b0) begin $display("FAIL fwd_idle got %b exp 0", fwd_valid); fails++; end
  endtask

  initial begin
    test_reset();
    test_select();
    test_load_ext();
    test_zero_addr();
    test_stall();
    test_back_to_back();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
